fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the 5-stage pipeline datapath. It tracks destination-register state for the EX, MEM and WB stages and drives the 2-bit `oper` selects of the two operand `MUX4x1` instances in front of the ALU. It also detects load-use hazards, raises a one-cycle stall, and injects bubbles on stall or flush. It sits beside the ID/EX pipeline register and is clocked with it.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/fwd_match.sv | 22 ++
 rtl/fwd_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: forwarding-select encodings and the
// destination-tracking entry kept for each of EX, MEM and WB.
package pipe_pkg;

  // Entries store the destination zero-extended to this width, so any
  // REG_AW up to 8 fits one shared struct type.
  localparam int unsigned PIPE_RD_W = 8;

  typedef logic [PIPE_RD_W-1:0] pipe_rd_t;

  typedef enum logic [1:0] {
    FWD_RF      = 2'd0,
    FWD_EXMEM   = 2'd1,
    FWD_MEMWB   = 2'd2,
    FWD_WBLATCH = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic     valid;
    pipe_rd_t rd;
    logic     reg_write;
    logic     is_load;
  } pipe_dst_t;

  // An entry supplies a source only if it is a live writer of a non-zero
  // register that equals the source, and the source is actually read.
  function automatic logic dst_hit(input pipe_dst_t e, input pipe_rd_t src,
                                   input logic use_src);
    return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src) && use_src;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority compare of one operand source against the EX, MEM and WB
// tracking entries; the newest matching producer wins.
module fwd_match
  import pipe_pkg::*;
(
  input  pipe_rd_t   src,
  input  logic       use_src,
  input  pipe_dst_t  ex,
  input  pipe_dst_t  mem,
  input  pipe_dst_t  wb,
  output logic [1:0] sel
);

  // EX > MEM > WB > register file
  always_comb begin
    sel = FWD_RF;
    if (dst_hit(ex, src, use_src))       sel = FWD_EXMEM;
    else if (dst_hit(mem, src, use_src)) sel = FWD_MEMWB;
    else if (dst_hit(wb, src, use_src))  sel = FWD_WBLATCH;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller beside the ID/EX register.
// Optional feature: define FWD_STATS_EN to add the saturating stall_count.
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid
`ifdef FWD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_count
`endif
);

  pipe_dst_t  ex_q, mem_q, wb_q;
  pipe_dst_t  ex_d;
  pipe_rd_t   rs_w, rt_w;
  logic [1:0] sel_a, sel_b;
  logic       hazard;
  logic       bubble;

  assign rs_w = PIPE_RD_W'(id_rs);
  assign rt_w = PIPE_RD_W'(id_rt);

  fwd_match u_match_a (
    .src     (rs_w),
    .use_src (id_use_rs),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (sel_a)
  );

  fwd_match u_match_b (
    .src     (rt_w),
    .use_src (id_use_rt),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (sel_b)
  );

  // Load-use detection and the bubble decision for the next EX entry
  always_comb begin
    hazard = id_valid && ex_q.is_load &&
             (dst_hit(ex_q, rs_w, id_use_rs) || dst_hit(ex_q, rt_w, id_use_rt));
    stall  = hazard && !flush;
    bubble = !id_valid || flush || hazard;
    ex_d   = '0;
    if (!bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = PIPE_RD_W'(id_rd);
      ex_d.reg_write = id_reg_write;
      ex_d.is_load   = id_is_load;
    end
  end

  // Tracking pipeline shifts every cycle; selects align with the EX entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_a_sel <= bubble ? FWD_RF : sel_a;
      fwd_b_sel <= bubble ? FWD_RF : sel_b;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;

`ifdef FWD_STATS_EN
  // Saturating count of cycles spent stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with hand-computed expectations.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_reg_write, id_is_load;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       ex_valid, mem_valid, wb_valid;
`ifdef FWD_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .STAT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .wb_valid     (wb_valid)
`ifdef FWD_STATS_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID instruction: rs, rt, use_rs, use_rt, rd, reg_write, is_load
  task automatic put(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
  endtask

  task automatic drain();
    nop();
    flush = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    nop();
    #3;
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valids", {ex_valid, mem_valid, wb_valid}, 0);
`ifdef FWD_STATS_EN
    chk("rst_count", stall_count, 0);
`endif
    #5 rst_n = 1'b1;

    // add r3 followed by sub reading r3 after k NOPs
    for (int k = 0; k < 4; k++) begin
      drain();
      put(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      tick();
      for (int n = 0; n < k; n++) begin
        nop();
        tick();
      end
      put(5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      chk($sformatf("raw_stall_k%0d", k), stall, 0);
      tick();
      nop();
      chk($sformatf("raw_fwd_a_k%0d", k), fwd_a_sel, (k == 3) ? 0 : k + 1);
      chk($sformatf("raw_fwd_b_k%0d", k), fwd_b_sel, 0);
      chk($sformatf("raw_exv_k%0d", k), ex_valid, 1);
    end

    // lw r5 then add reading r5 on rt
    drain();
    put(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    put(5'd1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 chk("lu_stall_on", stall, 1);
    tick();
    chk("lu_bubble_exv", ex_valid, 0);
    chk("lu_bubble_memv", mem_valid, 1);
    chk("lu_bubble_sel_b", fwd_b_sel, 0);
    chk("lu_stall_off", stall, 0);
    tick();
    nop();
    chk("lu_fwd_b", fwd_b_sel, 2);
    chk("lu_fwd_a", fwd_a_sel, 0);
    chk("lu_exv", ex_valid, 1);
    chk("lu_no_restall", stall, 0);
`ifdef FWD_STATS_EN
    chk("lu_count", stall_count, 1);
`endif

    // writes to r0 never forward or stall
    drain();
    put(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    put(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    #1 chk("r0_stall", stall, 0);
    tick();
    nop();
    chk("r0_fwd_a", fwd_a_sel, 0);
    chk("r0_fwd_b", fwd_b_sel, 0);

    // add r4, or r4, reader of r4: newest (EX) wins
    drain();
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    put(5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    put(5'd4, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    nop();
    chk("newest_fwd_a", fwd_a_sel, 1);
    chk("newest_fwd_b", fwd_b_sel, 1);

    // add r4, or r4, nop, reader: MEM beats WB
    drain();
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    put(5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    put(5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    nop();
    chk("mem_over_wb", fwd_a_sel, 2);

    // unused operand never forwards
    drain();
    put(5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    put(5'd11, 5'd11, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();
    nop();
    chk("unused_fwd_a", fwd_a_sel, 0);
    chk("used_fwd_b", fwd_b_sel, 1);

    // load-use coinciding with flush: no stall, EX gets a bubble
    drain();
    put(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    put(5'd0, 5'd9, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    nop();
    chk("flush_exv", ex_valid, 0);
    chk("flush_memv", mem_valid, 1);
    chk("flush_sel_b", fwd_b_sel, 0);
`ifdef FWD_STATS_EN
    chk("flush_count", stall_count, 1);
`endif

    // reset while stalled, then reader of the old load register
    drain();
    put(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    put(5'd9, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1 chk("rstmid_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall", stall, 0);
    chk("rstmid_valids", {ex_valid, mem_valid, wb_valid}, 0);
    chk("rstmid_sels", {fwd_a_sel, fwd_b_sel}, 0);
`ifdef FWD_STATS_EN
    chk("rstmid_count", stall_count, 0);
`endif
    #1 rst_n = 1'b1;
    tick();
    nop();
    chk("post_rst_fwd_a", fwd_a_sel, 0);
    chk("post_rst_exv", ex_valid, 1);
    chk("post_rst_stall", stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
